// File: rtl/therm_encoder.sv
// Thermometer-to-binary coarse encoder with sample checks,
// a repeat filter and a valid/ready output register.
module therm_encoder #(
  parameter int FILT_DEPTH = 3
) (
  input  logic        CLK_exit,
  input  logic        rst_n,
  input  logic        sample_en,
  input  logic [15:0] T,
  input  logic [15:0] Tb,
  output logic [3:0]  code,
  output logic        code_valid,
  input  logic        code_ready,
  output logic        shape_err,
  output logic        pair_err,
  output logic [7:0]  overrun_cnt,
  input  logic        clr_err
);

  localparam logic [2:0] DEPTH = 3'(FILT_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  logic [15:0] t_q, t_d;
  logic [15:0] tb_q, tb_d;
  logic        s1_vld_q, s1_vld_d;
  logic        s2_vld_q, s2_vld_d;

  logic [FILT_DEPTH-1:0][3:0] hist_q, hist_d;
  logic [2:0]  fill_q, fill_d;

  logic        shape_q, shape_d;
  logic        pair_q, pair_d;
  logic [7:0]  ovr_q, ovr_d;

  state_t      state_q, state_d;
  logic [3:0]  code_q, code_d;
  logic        dlv_q, dlv_d;

  logic [3:0]  raw;
  logic        shape_bad;
  logic        pair_bad;
  logic        stable;
  logic        offer;
  logic        load;
  logic        drop;

  // Stage 1: capture the delay-line readback when sampled
  always_comb begin
    t_d      = sample_en ? T : t_q;
    tb_d     = sample_en ? Tb : tb_q;
    s1_vld_d = sample_en;
    s2_vld_d = s1_vld_q;
  end

  // Stage 2: saturating popcount plus shape and pair checks
  always_comb begin
    logic [4:0] ones;
    ones = '0;
    for (int i = 0; i < 16; i++) begin
      ones = ones + {4'b0, t_q[i]};
    end
    raw       = ones[4] ? 4'hf : ones[3:0];
    shape_bad = |(t_q & (t_q + 16'd1));
    pair_bad  = (tb_q != ~t_q);
  end

  // Filter history: shift in good samples, flush on bad ones
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (s1_vld_q) begin
      if (shape_bad || pair_bad) begin
        fill_d = '0;
      end else begin
        for (int i = FILT_DEPTH - 1; i > 0; i--) begin
          hist_d[i] = hist_q[i-1];
        end
        hist_d[0] = raw;
        if (fill_q != DEPTH) begin
          fill_d = fill_q + 3'd1;
        end
      end
    end
  end

  // Stability and offer decision, evaluated once per new sample
  always_comb begin
    stable = (fill_q == DEPTH);
    for (int i = 1; i < FILT_DEPTH; i++) begin
      if (hist_q[i] != hist_q[0]) begin
        stable = 1'b0;
      end
    end
    offer = s2_vld_q && stable &&
            (!dlv_q || hist_q[0] != code_q);
  end

  // Output FSM next state
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (offer) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (code_ready) begin
          load    = offer;
          state_d = offer ? HOLD : IDLE;
        end else begin
          drop    = offer;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output FSM outputs
  always_comb begin
    code_valid = (state_q == HOLD);
    code       = code_q;
  end

  // Held code, delivery marker and sticky status
  always_comb begin
    code_d  = load ? hist_q[0] : code_q;
    dlv_d   = dlv_q | load;
    shape_d = (shape_q & ~clr_err) | (s1_vld_q & shape_bad);
    pair_d  = (pair_q & ~clr_err) | (s1_vld_q & pair_bad);
    ovr_d   = clr_err ? 8'd0 : ovr_q;
    if (drop && ovr_d != 8'hff) begin
      ovr_d = ovr_d + 8'd1;
    end
  end

  // Status outputs
  always_comb begin
    shape_err   = shape_q;
    pair_err    = pair_q;
    overrun_cnt = ovr_q;
  end

  // All state registers
  always_ff @(posedge CLK_exit or negedge rst_n) begin
    if (!rst_n) begin
      t_q      <= '0;
      tb_q     <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      hist_q   <= '0;
      fill_q   <= '0;
      shape_q  <= 1'b0;
      pair_q   <= 1'b0;
      ovr_q    <= '0;
      state_q  <= IDLE;
      code_q   <= '0;
      dlv_q    <= 1'b0;
    end else begin
      t_q      <= t_d;
      tb_q     <= tb_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      shape_q  <= shape_d;
      pair_q   <= pair_d;
      ovr_q    <= ovr_d;
      state_q  <= state_d;
      code_q   <= code_d;
      dlv_q    <= dlv_d;
    end
  end

endmodule

// File: tb/tb_therm_encoder.sv
// Self-checking bench for therm_encoder: vector table,
// transfer scoreboard and hand-written corner sequences.
module tb_therm_encoder;

  logic        clk;
  logic        rst_n;
  logic        sample_en;
  logic [15:0] t_in;
  logic [15:0] tb_in;
  logic [3:0]  code;
  logic        code_valid;
  logic        code_ready;
  logic        shape_err;
  logic        pair_err;
  logic [7:0]  overrun_cnt;
  logic        clr_err;

  int nchk;
  int nerr;
  int exp_q[$];

  typedef struct {
    logic [15:0] t;
    logic [15:0] tb;
    int          code;
    int          shape;
    int          pair;
    bit          dlv;
  } vec_t;

  vec_t vecs[11];

  therm_encoder #(.FILT_DEPTH(3)) dut (
    .CLK_exit    (clk),
    .rst_n       (rst_n),
    .sample_en   (sample_en),
    .T           (t_in),
    .Tb          (tb_in),
    .code        (code),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .shape_err   (shape_err),
    .pair_err    (pair_err),
    .overrun_cnt (overrun_cnt),
    .clr_err     (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Transfer monitor: a handshake seen here completes on the next edge
  always @(negedge clk) begin
    if (rst_n && code_valid && code_ready) begin
      if (exp_q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL xfer_unexpected: got %0d expected none", code);
      end else begin
        chk("xfer_code", int'(code), exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic samp(input logic [15:0] t, input logic [15:0] tb,
                      input int n);
    sample_en = 1'b1;
    t_in      = t;
    tb_in     = tb;
    ticks(n);
    sample_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    sample_en  = 1'b0;
    clr_err    = 1'b0;
    code_ready = 1'b0;
    t_in       = '0;
    tb_in      = '1;
    ticks(2);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic clear_flags();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  initial begin
    nchk = 0;
    nerr = 0;

    vecs[0]  = '{16'h003F, 16'hFFC0,  6, 0, 0, 1'b1};
    vecs[1]  = '{16'h0007, 16'hFFF8,  3, 0, 0, 1'b1};
    vecs[2]  = '{16'h0000, 16'hFFFF,  0, 0, 0, 1'b1};
    vecs[3]  = '{16'hFFFF, 16'h0000, 15, 0, 0, 1'b1};
    vecs[4]  = '{16'h00FF, 16'h0000,  0, 0, 1, 1'b0};
    vecs[5]  = '{16'h0005, 16'hFFFA,  0, 1, 0, 1'b0};
    vecs[6]  = '{16'h7FFF, 16'h8000, 15, 0, 0, 1'b0};
    vecs[7]  = '{16'h0001, 16'hFFFE,  1, 0, 0, 1'b1};
    vecs[8]  = '{16'h0001, 16'hFFFE,  1, 0, 0, 1'b0};
    vecs[9]  = '{16'h8000, 16'h7FFF,  0, 1, 0, 1'b0};
    vecs[10] = '{16'h03FF, 16'hFC00, 10, 0, 0, 1'b1};

    // Reset values
    rst_n      = 1'b0;
    sample_en  = 1'b0;
    clr_err    = 1'b0;
    code_ready = 1'b0;
    t_in       = '0;
    tb_in      = '0;
    ticks(2);
    @(negedge clk);
    chk("rst_valid", int'(code_valid), 0);
    chk("rst_code", int'(code), 0);
    chk("rst_shape", int'(shape_err), 0);
    chk("rst_pair", int'(pair_err), 0);
    chk("rst_ovr", int'(overrun_cnt), 0);

    // Latency: valid rises two clocks after the third sample
    do_reset();
    code_ready = 1'b1;
    exp_q.push_back(6);
    samp(16'h003F, 16'hFFC0, 3);
    @(negedge clk);
    chk("lat_c1", int'(code_valid), 0);
    @(negedge clk);
    chk("lat_c2", int'(code_valid), 0);
    @(negedge clk);
    chk("lat_c3", int'(code_valid), 1);
    chk("lat_code", int'(code), 6);
    @(negedge clk);
    chk("lat_pulse_end", int'(code_valid), 0);
    chk("lat_shape", int'(shape_err), 0);
    chk("lat_pair", int'(pair_err), 0);

    // Bubble in the middle flushes the filter
    do_reset();
    code_ready = 1'b1;
    exp_q.push_back(6);
    samp(16'h003F, 16'hFFC0, 1);
    samp(16'h0005, 16'hFFFA, 1);
    samp(16'h003F, 16'hFFC0, 1);
    @(negedge clk);
    chk("bub_early", int'(code_valid), 0);
    @(posedge clk);
    #1;
    samp(16'h003F, 16'hFFC0, 2);
    @(negedge clk);
    chk("bub_c1", int'(code_valid), 0);
    @(negedge clk);
    chk("bub_c2", int'(code_valid), 0);
    @(negedge clk);
    chk("bub_c3", int'(code_valid), 1);
    chk("bub_shape", int'(shape_err), 1);
    tick();
    clear_flags();
    chk("bub_shape_clr", int'(shape_err), 0);

    // Vector table
    do_reset();
    code_ready = 1'b1;
    foreach (vecs[i]) begin
      if (vecs[i].dlv) exp_q.push_back(vecs[i].code);
      samp(vecs[i].t, vecs[i].tb, 3);
      ticks(4);
      chk($sformatf("vec%0d_shape", i), int'(shape_err), vecs[i].shape);
      chk($sformatf("vec%0d_pair", i), int'(pair_err), vecs[i].pair);
      if (!vecs[i].shape && !vecs[i].pair)
        chk($sformatf("vec%0d_code", i), int'(code), vecs[i].code);
      clear_flags();
      chk($sformatf("vec%0d_clr", i), int'(pair_err | shape_err), 0);
    end
    chk("vec_queue", exp_q.size(), 0);

    // Error event beats clear on the same edge
    samp(16'h00FF, 16'h0000, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_vs_evt", int'(pair_err), 1);
    clear_flags();
    chk("clr_after", int'(pair_err), 0);

    // Overrun counting and saturation
    do_reset();
    samp(16'h003F, 16'hFFC0, 3);
    ticks(4);
    chk("ovr_hold", int'(code_valid), 1);
    chk("ovr_code6", int'(code), 6);
    samp(16'h03FF, 16'hFC00, 3);
    ticks(4);
    chk("ovr_code_kept", int'(code), 6);
    chk("ovr_one", int'(overrun_cnt), 1);
    samp(16'h03FF, 16'hFC00, 260);
    ticks(4);
    chk("ovr_sat", int'(overrun_cnt), 255);
    clear_flags();
    chk("ovr_clr", int'(overrun_cnt), 0);

    // Back-to-back transfer with no idle cycle
    exp_q.push_back(6);
    exp_q.push_back(15);
    samp(16'hFFFF, 16'h0000, 3);
    tick();
    code_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("b2b_valid", int'(code_valid), 1);
    chk("b2b_code", int'(code), 15);
    chk("b2b_shape", int'(shape_err), 0);
    tick();
    @(negedge clk);
    chk("b2b_idle", int'(code_valid), 0);
    code_ready = 1'b0;
    chk("b2b_queue", exp_q.size(), 0);

    // Asynchronous reset while holding
    samp(16'h0007, 16'hFFF8, 3);
    ticks(4);
    samp(16'h000F, 16'hFFF0, 3);
    samp(16'h00FF, 16'h0000, 1);
    ticks(4);
    chk("mid_valid", int'(code_valid), 1);
    chk("mid_ovr", int'(overrun_cnt), 1);
    chk("mid_pair", int'(pair_err), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(code_valid), 0);
    chk("arst_code", int'(code), 0);
    chk("arst_ovr", int'(overrun_cnt), 0);
    chk("arst_pair", int'(pair_err), 0);
    ticks(2);
    @(negedge clk);
    rst_n = 1'b1;
    code_ready = 1'b1;
    exp_q.push_back(3);
    tick();
    samp(16'h0007, 16'hFFF8, 3);
    ticks(5);
    chk("post_rst_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
